// File: rtl/timer_display_pkg.sv
// timer_display_pkg: shared widths, converter state encoding and seven-segment patterns.
package timer_display_pkg;
  localparam int NUM_DIGITS = 4;
  localparam int BIN_W = 12;
  typedef enum logic {IDLE, SHIFT} conv_state_e;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    return (d < 4'd10) ? SEG_LUT[d] : SEG_BLANK;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one shift per clock, BIN_W iterations.
module bin2bcd_seq
  import timer_display_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [BIN_W-1:0]        bin_i,
  output logic                    busy_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    done_o
);
  conv_state_e             state_q, state_d;
  logic [BIN_W-1:0]        bin_q, bin_d;
  logic [4*NUM_DIGITS-1:0] scr_q, scr_d, adj, bcd_q, bcd_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    done_q, done_d;
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i+:4] = (scr_q[4*i+:4] >= 4'd5) ? scr_q[4*i+:4] + 4'd3 : scr_q[4*i+:4];
    state_d = state_q;
    bin_d = bin_q;
    scr_d = scr_q;
    cnt_d = cnt_q;
    bcd_d = bcd_q;
    done_d = 1'b0;
    if (state_q == IDLE && start_i) begin
      state_d = SHIFT;
      bin_d = bin_i;
      scr_d = '0;
      cnt_d = '0;
    end else if (state_q == SHIFT) begin
      {scr_d, bin_d} = {adj, bin_q} << 1;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'(BIN_W - 1)) begin
        state_d = IDLE;
        bcd_d = {adj[4*NUM_DIGITS-2:0], bin_q[BIN_W-1]};
        done_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q <= bin_d;
      scr_q <= scr_d;
      cnt_q <= cnt_d;
      bcd_q <= bcd_d;
      done_q <= done_d;
    end
  end
  assign busy_o = (state_q == SHIFT);
  assign bcd_o = bcd_q;
  assign done_o = done_q;
endmodule

// File: rtl/time_display.sv
// time_display: synchronizes the timer count, converts it to BCD and drives a
// multiplexed 4-digit seven-segment display with blanking and time-out flash.
module time_display
  import timer_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 100_000,
  parameter int FLASH_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] counter,
  input  logic        time_out,
  output logic [15:0] bcd,
  output logic        bcd_valid,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp
);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FW = $clog2(FLASH_CYCLES + 1);
  logic [BIN_W-1:0] s1_q, s2_q, s3_q, last_bin_q, last_bin_d;
  logic [2:0]       to_q;
  logic [RW-1:0]    ref_q, ref_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [FW-1:0]    flash_q, flash_d;
  logic [15:0]      hi;
  logic             start, busy, rise, tc;
  // Only start on a sample that held for a full clock, so a half-captured count never converts
  assign start = (s2_q == s3_q) && (s2_q != last_bin_q) && !busy;
  assign rise = to_q[1] & ~to_q[2];
  assign tc = (ref_q == RW'(REFRESH_DIV - 1));
  always_comb begin
    last_bin_d = start ? s2_q : last_bin_q;
    ref_d = tc ? '0 : ref_q + 1'b1;
    idx_d = tc ? idx_q + 2'd1 : idx_q;
    hi = bcd >> {idx_q, 2'b00};
    an_d = ~(4'b0001 << idx_q);
    seg_d = (idx_q != 2'd0 && hi == 16'd0) ? SEG_BLANK : seg_decode(hi[3:0]);
    flash_d = rise ? FW'(FLASH_CYCLES) : (flash_q != '0) ? flash_q - 1'b1 : flash_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      last_bin_q <= '0;
      to_q <= '0;
      ref_q <= '0;
      idx_q <= '0;
      an_q <= 4'hF;
      seg_q <= SEG_BLANK;
      flash_q <= '0;
    end else begin
      s1_q <= counter;
      s2_q <= s1_q;
      s3_q <= s2_q;
      last_bin_q <= last_bin_d;
      to_q <= {to_q[1:0], time_out};
      ref_q <= ref_d;
      idx_q <= idx_d;
      an_q <= an_d;
      seg_q <= seg_d;
      flash_q <= flash_d;
    end
  end
  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .bin_i   (s2_q),
    .busy_o  (busy),
    .bcd_o   (bcd),
    .done_o  (bcd_valid)
  );
  assign seg = seg_q;
  assign an = an_q;
  assign dp = (flash_q == '0);
endmodule
